// File: rtl/router_reg_if.sv
// Bundle of the router FSM strobes, the input packet stream and the
// register-stage results that connects router_reg to the control path.
interface router_reg_if #(
  parameter int DW = 8
);
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic          detect_add;
  logic          lfd_state;
  logic          ld_state;
  logic          laf_state;
  logic          full_state;
  logic          rst_int_reg;
  logic          parity_done;
  logic          low_pkt_valid;
  logic          err;
  logic [DW-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, replays the byte stalled by
// a full FIFO, and accumulates/checks XOR parity for every packet.
module router_reg #(
  parameter int DW = 8
) (
  input logic       clk,
  input logic       reset,
  router_reg_if.slave bus
);

  logic [DW-1:0] r_header;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_int_par;
  logic [DW-1:0] r_pkt_par;
  logic [DW-1:0] r_dout;
  logic          r_err;
  logic          r_pd;
  logic          r_low;

  logic w_hdr_load;
  logic w_late_par;
  logic w_pkt_load;
  logic w_pd_set;
  logic w_fold;

  // Address 3 is not a valid destination, so such a header is never latched.
  assign w_hdr_load = bus.detect_add & bus.pkt_valid & (bus.data_in[1:0] != 2'b11);
  assign w_late_par = bus.laf_state & r_low & ~r_pd;
  assign w_pkt_load = (bus.ld_state & ~bus.pkt_valid) | w_late_par;
  assign w_pd_set   = (bus.ld_state & ~bus.fifo_full & ~bus.pkt_valid) | w_late_par;
  assign w_fold     = bus.ld_state & bus.pkt_valid & ~bus.full_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_header <= '0;
    else if (w_hdr_load) r_header <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_hold <= '0;
    else if (bus.ld_state & bus.fifo_full) r_hold <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_dout <= '0;
    else if (bus.lfd_state)                   r_dout <= r_header;
    else if (bus.ld_state & ~bus.fifo_full)   r_dout <= bus.data_in;
    else if (bus.ld_state)                    r_dout <= r_dout;
    else if (bus.laf_state)                   r_dout <= r_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_int_par <= '0;
    else if (bus.detect_add) r_int_par <= '0;
    else if (bus.lfd_state)  r_int_par <= r_int_par ^ r_header;
    else if (w_fold)         r_int_par <= r_int_par ^ bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_pkt_par <= '0;
    else if (w_pkt_load)     r_pkt_par <= bus.data_in;
    else if (bus.detect_add) r_pkt_par <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_pd <= 1'b0;
    else if (w_pd_set)       r_pd <= 1'b1;
    else if (bus.detect_add) r_pd <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_low <= 1'b0;
    else if (bus.ld_state & ~bus.pkt_valid) r_low <= 1'b1;
    else if (bus.rst_int_reg)            r_low <= 1'b0;
  end

  // detect_add wins so a back-to-back header clears err on the same edge
  // while parity_done from the previous packet is still high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_err <= 1'b0;
    else if (bus.detect_add) r_err <= 1'b0;
    else if (r_pd)           r_err <= (r_int_par != r_pkt_par);
  end

  assign bus.dout          = r_dout;
  assign bus.err           = r_err;
  assign bus.parity_done   = r_pd;
  assign bus.low_pkt_valid = r_low;

endmodule

// File: tb/tb_router_reg.sv
// Drives router_reg with FSM-shaped packet sequences and checks the written byte
// stream, parity flags and error result against packet-level expectations.
module tb_router_reg;

  logic clk;
  logic reset;
  int unsigned n_chk;
  int unsigned n_pass;
  logic [7:0] last_hdr;

  router_reg_if #(.DW(8)) rif ();

  router_reg #(.DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rif.pkt_valid   = 1'b0;
    rif.fifo_full   = 1'b0;
    rif.detect_add  = 1'b0;
    rif.lfd_state   = 1'b0;
    rif.ld_state    = 1'b0;
    rif.laf_state   = 1'b0;
    rif.full_state  = 1'b0;
    rif.rst_int_reg = 1'b0;
  endtask

  task automatic full_wait(input int unsigned cycles, input logic [7:0] d, input logic pv);
    for (int unsigned c = 0; c < cycles; c++) begin
      clr();
      rif.full_state = 1'b1;
      rif.fifo_full  = 1'b1;
      rif.pkt_valid  = pv;
      rif.data_in    = d;
      tick();
    end
  endtask

  // full_at: payload index stalled by a full FIFO, len = parity byte, -1 = none
  task automatic send_packet(input logic [1:0] addr, input logic [7:0] pl[$],
                             input logic [7:0] bad_xor, input int full_at,
                             input int unsigned full_cycles);
    logic [7:0] hdr, par, nxt;
    logic [7:0] exp_q[$];
    logic       exp_err;
    int unsigned len, k;
    logic        nxt_pv;
    len = pl.size();
    hdr = {6'(len), addr};
    par = hdr;
    foreach (pl[i]) par ^= pl[i];
    par ^= bad_xor;
    exp_err = (bad_xor != 8'h00);
    exp_q.push_back(hdr);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    exp_q.push_back(par);
    k = 0;

    clr(); rif.detect_add = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = hdr; tick();
    check("da_err", rif.err, 0);
    check("da_pd", rif.parity_done, 0);
    last_hdr = hdr;

    clr(); rif.lfd_state = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = pl[0]; tick();
    check("dout_hdr", rif.dout, exp_q[k]); k++;

    for (int i = 0; i < int'(len); i++) begin
      clr(); rif.ld_state = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = pl[i];
      if (i == full_at) begin
        rif.fifo_full = 1'b1;
        tick();
        check("dout_stall", rif.dout, exp_q[k-1]);
        nxt_pv = (i + 1 < int'(len));
        nxt    = nxt_pv ? pl[i+1] : par;
        full_wait(full_cycles, nxt, nxt_pv);
        clr(); rif.laf_state = 1'b1; rif.pkt_valid = nxt_pv; rif.data_in = nxt; tick();
        check("dout_replay", rif.dout, exp_q[k]); k++;
      end else begin
        tick();
        check("dout_pay", rif.dout, exp_q[k]); k++;
      end
    end

    clr(); rif.ld_state = 1'b1; rif.pkt_valid = 1'b0; rif.data_in = par;
    if (full_at == int'(len)) begin
      rif.fifo_full = 1'b1;
      tick();
      check("pf_low", rif.low_pkt_valid, 1);
      check("pf_pd", rif.parity_done, 0);
      check("pf_dout", rif.dout, exp_q[k-1]);
      full_wait(full_cycles, par, 1'b0);
      clr(); rif.laf_state = 1'b1; rif.data_in = par; tick();
      check("dout_par_laf", rif.dout, exp_q[k]); k++;
      check("pd_laf", rif.parity_done, 1);
    end else begin
      tick();
      check("dout_par", rif.dout, exp_q[k]); k++;
      check("pd_ld", rif.parity_done, 1);
      check("low_ld", rif.low_pkt_valid, 1);
    end

    clr(); tick();
    clr(); rif.rst_int_reg = 1'b1;
    check("err_chk", rif.err, exp_err);
    check("low_chk", rif.low_pkt_valid, 1);
    tick();
    check("low_clr", rif.low_pkt_valid, 0);
    check("err_hold", rif.err, exp_err);
    clr(); tick();
  endtask

  task automatic addr3_probe();
    logic [7:0] bad_hdr;
    bad_hdr = {6'($urandom_range(0, 63)), 2'b11};
    clr(); rif.detect_add = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = bad_hdr; tick();
    clr(); rif.lfd_state = 1'b1; rif.pkt_valid = 1'b1; tick();
    check("addr3_hdr", rif.dout, last_hdr);
    clr(); tick();
  endtask

  initial begin
    logic [7:0] pl[$];
    int unsigned len;
    int fa;
    n_chk = 0;
    n_pass = 0;
    last_hdr = 8'h00;
    clr();
    rif.data_in = 8'h00;
    reset = 1'b1;
    tick(); tick();
    check("rst_dout", rif.dout, 0);
    check("rst_err", rif.err, 0);
    check("rst_pd", rif.parity_done, 0);
    check("rst_low", rif.low_pkt_valid, 0);
    reset = 1'b0;
    tick();

    pl = '{8'h11, 8'h22, 8'h33};
    send_packet(2'd1, pl, 8'h00, -1, 0);
    send_packet(2'd1, pl, 8'hF2, -1, 0);
    send_packet(2'd1, pl, 8'h00, 1, 2);
    send_packet(2'd1, pl, 8'h00, 3, 2);
    addr3_probe();

    // reset between edges, in the middle of a payload
    clr(); rif.detect_add = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = 8'h0D; tick();
    clr(); rif.lfd_state = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = 8'h11; tick();
    clr(); rif.ld_state = 1'b1; rif.pkt_valid = 1'b0; rif.data_in = 8'h11; tick();
    check("pre_rst_low", rif.low_pkt_valid, 1);
    #3 reset = 1'b1;
    #1;
    check("arst_dout", rif.dout, 0);
    check("arst_low", rif.low_pkt_valid, 0);
    check("arst_pd", rif.parity_done, 0);
    check("arst_err", rif.err, 0);
    clr();
    #2 reset = 1'b0;
    tick();
    send_packet(2'd1, pl, 8'h00, -1, 0);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 8);
      pl.delete();
      for (int unsigned i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
      send_packet(2'($urandom_range(0, 2)), pl,
                  ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                  fa, $urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) addr3_probe();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
